// File: rtl/writeback_stage_if.sv
// Bus bundle for the MEM/WB writeback stage.
//   master : upstream view (EX/MEM pipeline regs, data memory, decode read port)
//            drives instruction, memory and read-index inputs; observes stall,
//            the register file write port, bypassed read data and retired count.
//   slave  : the writeback stage itself.
interface writeback_stage_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
);
  logic              in_valid;
  logic              in_reg_write;
  logic              in_mem_read;
  logic [ADDR_W-1:0] in_write_reg;
  logic [DATA_W-1:0] in_alu_result;
  logic [DATA_W-1:0] dmem_rdata;
  logic              dmem_ready;
  logic              stall;
  logic              WB;
  logic [ADDR_W-1:0] writeReg;
  logic [DATA_W-1:0] writeData;
  logic [ADDR_W-1:0] readReg1;
  logic [ADDR_W-1:0] readReg2;
  logic [DATA_W-1:0] rf_data1;
  logic [DATA_W-1:0] rf_data2;
  logic [DATA_W-1:0] byp_data1;
  logic [DATA_W-1:0] byp_data2;
  logic [CNT_W-1:0]  retired;

  modport master (
    output in_valid, in_reg_write, in_mem_read, in_write_reg, in_alu_result,
           dmem_rdata, dmem_ready, readReg1, readReg2, rf_data1, rf_data2,
    input  stall, WB, writeReg, writeData, byp_data1, byp_data2, retired
  );

  modport slave (
    input  in_valid, in_reg_write, in_mem_read, in_write_reg, in_alu_result,
           dmem_rdata, dmem_ready, readReg1, readReg2, rf_data1, rf_data2,
    output stall, WB, writeReg, writeData, byp_data1, byp_data2, retired
  );
endinterface

// File: rtl/writeback_stage.sv
// MEM/WB stage of the MIPS datapath.
// Registers the retiring instruction, picks ALU result or load data, and drives
// the register file write port (WB/writeReg/writeData). A load whose data memory
// is not ready parks in WAIT_MEM and stalls upstream until dmem_ready. The
// pending write is bypassed onto both decode read ports.
// Ports: clk, rst (async, active-high), bus (writeback_stage_if.slave).

// One decode read port's bypass mux.
module writeback_bypass_lane #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              wb,
  input  logic [ADDR_W-1:0] wr_reg,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_reg,
  input  logic [DATA_W-1:0] rf_data,
  output logic [DATA_W-1:0] byp
);
  // $0 reads never bypass; WB is already 0 for $0 writes but keep it explicit.
  assign byp = (wb && (rd_reg == wr_reg) && (|rd_reg)) ? wr_data : rf_data;
endmodule

module writeback_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
) (
  input  logic            clk,
  input  logic            rst,
  writeback_stage_if.slave bus
);
  localparam int NUM_RD = 2;

  typedef enum logic {RUN = 1'b0, WAIT_MEM = 1'b1} state_t;

  state_t            state, state_nxt;
  logic              accept, miss, fill, stall_c;
  logic              wb_q;
  logic [ADDR_W-1:0] wreg_q;
  logic [DATA_W-1:0] wdata_q;
  logic [CNT_W-1:0]  ret_q;
  logic              pend_rw;
  logic [ADDR_W-1:0] pend_reg;

  // accept: retire straight from EX/MEM; miss: load parks; fill: parked load retires
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    miss      = 1'b0;
    fill      = 1'b0;
    unique case (state)
      RUN: begin
        if (bus.in_valid) begin
          if (!bus.in_mem_read || bus.dmem_ready) begin
            accept = 1'b1;
          end else begin
            miss      = 1'b1;
            state_nxt = WAIT_MEM;
          end
        end
      end
      WAIT_MEM: begin
        // upstream is holding the same load, so in_* is not looked at here
        if (bus.dmem_ready) begin
          fill      = 1'b1;
          state_nxt = RUN;
        end
      end
      default: state_nxt = RUN;
    endcase
    stall_c = (miss || (state == WAIT_MEM && !bus.dmem_ready)) && !rst;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_q     <= 1'b0;
      wreg_q   <= '0;
      wdata_q  <= '0;
      ret_q    <= '0;
      pend_rw  <= 1'b0;
      pend_reg <= '0;
    end else begin
      wb_q <= 1'b0;  // bubble unless something retires
      if (accept) begin
        wb_q    <= bus.in_reg_write && (|bus.in_write_reg);
        wreg_q  <= bus.in_write_reg;
        wdata_q <= bus.in_mem_read ? bus.dmem_rdata : bus.in_alu_result;
        ret_q   <= ret_q + CNT_W'(1);
      end else if (fill) begin
        wb_q    <= pend_rw && (|pend_reg);
        wreg_q  <= pend_reg;
        wdata_q <= bus.dmem_rdata;
        ret_q   <= ret_q + CNT_W'(1);
      end
      if (miss) begin
        pend_rw  <= bus.in_reg_write;
        pend_reg <= bus.in_write_reg;
      end
    end
  end

  logic [NUM_RD-1:0][ADDR_W-1:0] rd_reg;
  logic [NUM_RD-1:0][DATA_W-1:0] rf_data;
  logic [NUM_RD-1:0][DATA_W-1:0] byp;

  assign rd_reg  = {bus.readReg2, bus.readReg1};
  assign rf_data = {bus.rf_data2, bus.rf_data1};

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    writeback_bypass_lane #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_lane (
      .wb      (wb_q),
      .wr_reg  (wreg_q),
      .wr_data (wdata_q),
      .rd_reg  (rd_reg[i]),
      .rf_data (rf_data[i]),
      .byp     (byp[i])
    );
  end

  assign bus.stall     = stall_c;
  assign bus.WB        = wb_q;
  assign bus.writeReg  = wreg_q;
  assign bus.writeData = wdata_q;
  assign bus.retired   = ret_q;
  assign bus.byp_data1 = byp[0];
  assign bus.byp_data2 = byp[1];
endmodule

// File: tb/tb_writeback_stage.sv
// Testbench for writeback_stage: directed scenarios then random instruction
// stream. The driver pushes each retirement's expected write into a queue; a
// monitor pops whenever the retired counter moves and checks the write port,
// and checks both bypass outputs every cycle.
module tb_writeback_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  writeback_stage_if #(.DATA_W(32), .ADDR_W(5), .CNT_W(32)) bus ();

  writeback_stage #(.DATA_W(32), .ADDR_W(5), .CNT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        wb;
    logic [4:0]  r;
    logic [31:0] d;
    logic [31:0] cnt;
  } exp_t;

  exp_t        q[$];
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] model_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // one retirement as seen from the architecture: write $r unless r==0 or no write
  task automatic push(input bit rw, input logic [4:0] r, input logic [31:0] d);
    exp_t e;
    model_cnt++;
    e.wb = rw && (r != 0);
    e.r = r;
    e.d = d;
    e.cnt = model_cnt;
    q.push_back(e);
  endtask

  // drive one cycle after the edge, check stall mid-cycle
  task automatic cycle(input bit v, input bit rw, input bit mr, input logic [4:0] r,
                       input logic [31:0] alu, input logic [31:0] rd, input bit rdy,
                       input bit exp_stall);
    @(posedge clk);
    #1;
    bus.in_valid      = v;
    bus.in_reg_write  = rw;
    bus.in_mem_read   = mr;
    bus.in_write_reg  = r;
    bus.in_alu_result = alu;
    bus.dmem_rdata    = rd;
    bus.dmem_ready    = rdy;
    bus.readReg1      = 5'($urandom_range(0, 7));
    bus.readReg2      = 5'($urandom_range(0, 7));
    bus.rf_data1      = $urandom;
    bus.rf_data2      = $urandom;
    @(negedge clk);
    chk("stall", {31'd0, bus.stall}, {31'd0, exp_stall});
  endtask

  // issue one instruction; a load with lat>0 waits lat cycles for memory
  task automatic issue(input bit v, input bit rw, input bit mr, input logic [4:0] r,
                       input logic [31:0] alu, input logic [31:0] rd, input int lat);
    if (v && mr && lat > 0) begin
      cycle(1'b1, rw, 1'b1, r, alu, $urandom, 1'b0, 1'b1);
      // the stage must ignore in_* while parked, so scramble them
      for (int k = 1; k < lat; k++)
        cycle(1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom), $urandom, $urandom,
              1'b0, 1'b1);
      cycle(1'b1, rw, 1'b1, r, alu, rd, 1'b1, 1'b0);
      push(rw, r, rd);
    end else begin
      cycle(v, rw, mr, r, alu, mr ? rd : $urandom, mr ? 1'b1 : 1'($urandom), 1'b0);
      if (v) push(rw, r, mr ? rd : alu);
    end
  endtask

  // monitor: architectural view of the write port and bypass
  initial begin : monitor
    logic [31:0] last_ret;
    logic        cur_wb;
    logic [4:0]  cur_r;
    logic [31:0] cur_d;
    exp_t        e;
    last_ret = 0; cur_wb = 0; cur_r = 0; cur_d = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        last_ret = 0; cur_wb = 0; cur_r = 0; cur_d = 0;
      end else begin
        if (bus.retired !== last_ret) begin
          if (q.size() == 0) begin
            chk("unexpected_retire", bus.retired, last_ret);
            last_ret = bus.retired;
            cur_wb = 0;
          end else begin
            e = q.pop_front();
            chk("retired", bus.retired, e.cnt);
            chk("WB", {31'd0, bus.WB}, {31'd0, e.wb});
            chk("writeReg", {27'd0, bus.writeReg}, {27'd0, e.r});
            chk("writeData", bus.writeData, e.d);
            last_ret = e.cnt;
            cur_wb = e.wb; cur_r = e.r; cur_d = e.d;
          end
        end else begin
          cur_wb = 0;
          chk("WB_idle", {31'd0, bus.WB}, 32'd0);
        end
        chk("byp_data1", bus.byp_data1,
            (cur_wb && cur_r == bus.readReg1 && bus.readReg1 != 0) ? cur_d : bus.rf_data1);
        chk("byp_data2", bus.byp_data2,
            (cur_wb && cur_r == bus.readReg2 && bus.readReg2 != 0) ? cur_d : bus.rf_data2);
      end
    end
  end

  initial begin : driver
    // reset with a missing load on the inputs: stall must still be low
    bus.in_valid = 1; bus.in_reg_write = 1; bus.in_mem_read = 1; bus.in_write_reg = 5'd9;
    bus.in_alu_result = 0; bus.dmem_rdata = 0; bus.dmem_ready = 0;
    bus.readReg1 = 0; bus.readReg2 = 0; bus.rf_data1 = 0; bus.rf_data2 = 0;
    #3;
    chk("rst_stall", {31'd0, bus.stall}, 32'd0);
    chk("rst_WB", {31'd0, bus.WB}, 32'd0);
    chk("rst_writeReg", {27'd0, bus.writeReg}, 32'd0);
    chk("rst_writeData", bus.writeData, 32'd0);
    chk("rst_retired", bus.retired, 32'd0);
    bus.in_valid = 0;
    @(negedge clk);
    rst = 0;

    // directed
    issue(1, 1, 0, 5'd20, 32'd50, 32'd0, 0);
    issue(1, 1, 1, 5'd8, 32'd0, 32'hDEADBEEF, 2);
    issue(1, 1, 0, 5'd0, 32'd7, 32'd0, 0);
    issue(0, 0, 0, 5'd0, 32'd0, 32'd0, 0);
    issue(0, 0, 0, 5'd0, 32'd0, 32'd0, 0);

    // reset while a load is parked
    cycle(1'b1, 1'b1, 1'b1, 5'd6, 32'd0, 32'd0, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 1'b1, 5'd6, 32'd0, 32'd0, 1'b0, 1'b1);
    #1;
    rst = 1;
    bus.in_valid = 0;
    #1;
    chk("midrst_stall", {31'd0, bus.stall}, 32'd0);
    chk("midrst_WB", {31'd0, bus.WB}, 32'd0);
    chk("midrst_retired", bus.retired, 32'd0);
    model_cnt = 0;
    @(negedge clk);
    #1;
    rst = 0;
    // late memory response must not write anything
    cycle(1'b0, 1'b1, 1'b1, 5'd6, 32'd0, 32'h5555AAAA, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("midrst_no_write", bus.retired, 32'd0);

    // back-to-back ALU, load hit, ALU
    issue(1, 1, 0, 5'd3, 32'd1, 32'd0, 0);
    issue(1, 1, 1, 5'd4, 32'd0, 32'd2, 0);
    issue(1, 1, 0, 5'd5, 32'd3, 32'd0, 0);
    issue(0, 0, 0, 5'd0, 32'd0, 32'd0, 0);
    chk("b2b_retired", bus.retired, 32'd3);

    // random stream; small register range so bypass hits often
    for (int n = 0; n < 400; n++) begin
      issue(($urandom % 5) != 0, ($urandom % 4) != 0, ($urandom % 3) == 0,
            5'($urandom_range(0, 7)), $urandom, $urandom, $urandom_range(0, 3));
    end

    repeat (3) issue(0, 0, 0, 5'd0, 32'd0, 32'd0, 0);
    chk("queue_drained", q.size(), 32'd0);
    chk("final_retired", bus.retired, model_cnt);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- MEM/WB pipeline stage of the MIPS datapath, directly upstream of the register file.
- Registers the retiring instruction's result, selects the ALU result or the load data, and drives the register file write port (WB, writeReg, writeData).
- Stalls upstream while a load waits on a multi-cycle data memory.
- Bypasses its own pending write onto the decode read data, so same-cycle write/read of one register returns the new value.

Parameters:
- DATA_W, 32, datapath width.
- ADDR_W, 5, register index width.
- CNT_W, 32, width of retired-instruction counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  EX/MEM holds a valid instruction.
- in_reg_write  in  1  instruction writes a register.
- in_mem_read  in  1  instruction is a load.
- in_write_reg  in  ADDR_W  destination register index.
- in_alu_result  in  DATA_W  ALU result.
- dmem_rdata  in  DATA_W  data memory read data.
- dmem_ready  in  1  dmem_rdata valid this cycle.
- stall  out  1  upstream must hold its registers.
- WB  out  1  register file write enable.
- writeReg  out  ADDR_W  register file write index.
- writeData  out  DATA_W  register file write data.
- readReg1, readReg2  in  ADDR_W  decode read indices, same as sent to the register file.
- rf_data1, rf_data2  in  DATA_W  register file RegData1/RegData2.
- byp_data1, byp_data2  out  DATA_W  bypass-corrected read data.
- retired  out  CNT_W  count of completed instructions.

Behaviour:
- Reset (async, any state): state=RUN; WB=0, writeReg=0, writeData=0, retired=0, pending registers cleared. stall=0 while rst is high.
- The FSM has two states, RUN and WAIT_MEM.
- RUN, in_valid=0: next WB=0 (bubble); writeReg and writeData hold.
- RUN, in_valid=1 and (in_mem_read=0 or dmem_ready=1):
  - Accept the instruction with 1-cycle latency.
  - Next edge: WB = in_reg_write and (in_write_reg != 0); writeReg = in_write_reg; writeData = dmem_rdata if in_mem_read, else in_alu_result.
  - retired increments.
- RUN, in_valid=1, in_mem_read=1, dmem_ready=0:
  - stall=1 combinationally.
  - Latch in_reg_write and in_write_reg into pending registers.
  - Next WB=0; go to WAIT_MEM.
- WAIT_MEM, dmem_ready=0:
  - stall=1; WB=0 each cycle.
  - in_* are ignored, because upstream is holding the same load.
- WAIT_MEM, dmem_ready=1:
  - stall=0 in this cycle.
  - Next edge: WB = pending_reg_write and (pending_reg != 0); writeReg = pending_reg; writeData = dmem_rdata.
  - retired increments; go to RUN.
  - in_* are not accepted in this cycle; upstream advances on this edge.
- stall is purely combinational: (RUN and in_valid and in_mem_read and not dmem_ready) or (WAIT_MEM and not dmem_ready).
- Register 0 is never written: WB is forced to 0 when the destination is 0, but the instruction still counts as retired.
- Bypass (combinational):
  - byp_data1 = writeData when WB=1, writeReg == readReg1 and readReg1 != 0; otherwise rf_data1.
  - byp_data2 follows the same rule with readReg2/rf_data2.
  - If both read indices match, both are bypassed.
- retired wraps modulo 2^CNT_W.
- Reset asserted during WAIT_MEM abandons the pending load: no write, no count.
- A dmem_ready pulse while in RUN for a non-load is ignored.

Test Plan:
- Reset then ALU op: in_valid=1, reg_write=1, write_reg=20, alu=50 -> next edge WB=1, writeReg=20, writeData=50, retired=1, stall stays 0.
- Load with 3-cycle memory: in_mem_read=1, write_reg=8, dmem_ready low for 2 cycles then high with rdata=0xDEADBEEF -> stall=1 for 2 cycles; WB=0 during the wait; WB=1, writeReg=8, writeData=0xDEADBEEF one edge after ready; retired incremented once.
- Write to $0: reg_write=1, write_reg=0, alu=7 -> WB=0; retired increments; byp_data1 with readReg1=0 equals rf_data1.
- Bypass: WB=1, writeReg=5, writeData=0x1234; readReg1=5, readReg2=6, rf_data1=0, rf_data2=9 -> byp_data1=0x1234, byp_data2=9.
- Reset mid-wait: load pending in WAIT_MEM, rst pulsed -> stall=0, WB=0, retired=0, state RUN; a later dmem_ready=1 causes no write.
- Back-to-back: ALU(r3=1), load hit with same-cycle ready (r4=2), ALU(r5=3) on consecutive cycles -> three consecutive WB=1 writes, no stall, retired=3.
